// File: rtl/instr_fetch_mem_pkg.sv
// Shared definitions for the instruction-fetch memory: fault codes, NOP fill
// value, the fetch pipeline stage record and the fault classifier.
package imem_pkg;

    // Widest instruction word a pipeline stage can carry.
    localparam int unsigned IMEM_DATA_W = 32;

    // Power-up fill value for every word of the array.
    localparam logic [31:0] NOP_INSN = 32'hD503201F;

    typedef enum logic [1:0] {
        FAULT_OK       = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_RANGE    = 2'b10
    } fault_e;

    typedef struct packed {
        logic                   valid;
        fault_e                 fault;
        logic [IMEM_DATA_W-1:0] data;
    } fetch_stage_t;

    // Misalignment is reported in preference to an out-of-range word index.
    function automatic fault_e classify_fault(input logic misaligned, input logic out_of_range);
        if (misaligned) begin
            return FAULT_MISALIGN;
        end
        if (out_of_range) begin
            return FAULT_RANGE;
        end
        return FAULT_OK;
    endfunction

endpackage

// File: rtl/instr_fetch_mem_if.sv
// Fetch request / response handshake bundle.
interface instr_fetch_mem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 64
) ();
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [1:0]        rsp_fault;

    // Requester side: issues fetches, consumes responses.
    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_fault
    );

    // Memory side: accepts fetches, produces responses.
    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_fault
    );
endinterface

// File: rtl/instr_fetch_mem_array.sv
// Instruction storage: one synchronous write port, one asynchronous read port.
// The read is combinational, so a same-cycle write is seen only from the
// next cycle on (read-before-write).
module imem_array
    import imem_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 64,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);
    // Array starts out filled with NOPs; only load writes change it.
    logic [DATA_W-1:0] mem_q [DEPTH] = '{default: DATA_W'(NOP_INSN)};

    assign rd_data = mem_q[rd_idx];

    // Program-load write, unaffected by reset or handshake state.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end
endmodule

// File: rtl/instr_fetch_mem.sv
// Instruction fetch memory: valid/ready fetch port with a fixed-latency
// read pipeline, fault decode and a saturating fault counter.
module instr_fetch_mem
    import imem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 64,
    parameter int DEPTH  = 64,
    parameter int RD_LAT = 2
) (
    input  logic                     CLK,
    input  logic                     Reset,
    instr_fetch_mem_if.slave         bus,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [DATA_W-1:0]        ld_data,
    output logic [15:0]              fault_cnt
);
    localparam int IDX_W = $clog2(DEPTH);

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
        $error("instr_fetch_mem: RD_LAT must be in 1..4");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("instr_fetch_mem: DEPTH must be a power of two >= 2");
    end
    if (DATA_W > IMEM_DATA_W || ADDR_W < IDX_W + 3) begin : g_bad_width
        $error("instr_fetch_mem: unsupported DATA_W/ADDR_W");
    end

    fetch_stage_t      pipe_q [RD_LAT];
    fetch_stage_t      pipe_d [RD_LAT];
    fetch_stage_t      stage_in;
    fetch_stage_t      head;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] rd_data;
    fault_e            req_fault;
    logic              rsp_valid_w;
    logic              advance;
    logic              accept;
    logic [15:0]       fault_cnt_q;
    logic [15:0]       fault_cnt_d;

    imem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (CLK),
        .wr_en   (ld_en),
        .wr_idx  (ld_addr),
        .wr_data (ld_data),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    assign rd_idx    = bus.req_addr[IDX_W+1:2];
    assign req_fault = classify_fault(|bus.req_addr[1:0], |bus.req_addr[ADDR_W-1:IDX_W+2]);

    // The whole pipeline moves together; it only freezes while the head
    // response is being refused. Reset hides the head immediately.
    assign head          = pipe_q[RD_LAT-1];
    assign rsp_valid_w   = head.valid && !Reset;
    assign advance       = !rsp_valid_w || bus.rsp_ready;
    assign bus.req_ready = Reset || advance;
    assign accept        = bus.req_valid && advance && !Reset;

    assign bus.rsp_valid = rsp_valid_w;
    assign bus.rsp_data  = rsp_valid_w ? head.data[DATA_W-1:0] : '0;
    assign bus.rsp_fault = rsp_valid_w ? head.fault : FAULT_OK;
    assign fault_cnt     = fault_cnt_q;

    // Next-state of the read pipeline: load the accepted request, shift on advance.
    always_comb begin
        stage_in       = '0;
        stage_in.valid = accept;
        stage_in.fault = req_fault;
        if (req_fault == FAULT_OK) begin
            stage_in.data[DATA_W-1:0] = rd_data;
        end
        for (int i = 0; i < RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i];
        end
        if (advance) begin
            pipe_d[0] = stage_in;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end
    end

    // Count delivered faulted responses, saturating at all-ones.
    always_comb begin
        fault_cnt_d = fault_cnt_q;
        if (rsp_valid_w && bus.rsp_ready && head.fault != FAULT_OK && fault_cnt_q != 16'hFFFF) begin
            fault_cnt_d = fault_cnt_q + 16'd1;
        end
    end

    // Pipeline and counter state; reset clears only valid bits and the counter.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i].valid <= 1'b0;
            end
            fault_cnt_q <= '0;
        end else begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
            fault_cnt_q <= fault_cnt_d;
        end
    end
endmodule

// File: tb/tb_instr_fetch_mem.sv
// Scoreboard bench for instr_fetch_mem: stimulus pushes expected responses,
// a negedge monitor pops and compares every delivered response.
module tb_instr_fetch_mem;
    import imem_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 64;
    localparam int DEPTH  = 64;
    localparam int RD_LAT = 2;
    localparam int IDX_W  = 6;

    logic              CLK = 1'b0;
    logic              Reset;
    logic              ld_en;
    logic [IDX_W-1:0]  ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic [15:0]       fault_cnt;

    instr_fetch_mem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    instr_fetch_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .RD_LAT (RD_LAT)
    ) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .bus       (bus),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .fault_cnt (fault_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  fault;
        int          due;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    bit          chk_lat = 1'b0;
    bit          hold_prev = 1'b0;
    logic [31:0] hold_data;
    logic [1:0]  hold_fault;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    // Monitor: response ordering/content, stall stability, backpressure on req_ready.
    initial forever begin
        @(negedge CLK);
        if (Reset) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("stall_valid_held", 64'(bus.rsp_valid), 64'h1);
                check("stall_data_held", 64'(bus.rsp_data), 64'(hold_data));
                check("stall_fault_held", 64'(bus.rsp_fault), 64'(hold_fault));
            end
            if (bus.rsp_valid && !bus.rsp_ready) begin
                check("stall_req_ready", 64'(bus.req_ready), 64'h0);
                hold_prev  = 1'b1;
                hold_data  = bus.rsp_data;
                hold_fault = bus.rsp_fault;
            end else begin
                hold_prev = 1'b0;
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_rsp: got data 0x%0h fault %0d, expected none", bus.rsp_data, bus.rsp_fault);
                end else begin
                    mon_e = sb.pop_front();
                    check("rsp_data", 64'(bus.rsp_data), 64'(mon_e.data));
                    check("rsp_fault", 64'(bus.rsp_fault), 64'(mon_e.fault));
                    if (chk_lat) begin
                        check("rsp_latency", 64'(cyc), 64'(mon_e.due));
                    end
                end
            end
        end
    end

    task automatic ld(input int idx, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = IDX_W'(idx);
        ld_data = d;
        @(posedge CLK);
        #1;
        ld_en = 1'b0;
    endtask

    task automatic fetch(input logic [63:0] a, input logic [31:0] d, input logic [1:0] f);
        int   n;
        exp_t e;
        n = 0;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        @(negedge CLK);
        while (!bus.req_ready && n < 40) begin
            @(negedge CLK);
            n++;
        end
        if (!bus.req_ready) begin
            fail_now("req_accept");
            bus.req_valid = 1'b0;
        end else begin
            e.data  = d;
            e.fault = f;
            e.due   = cyc + RD_LAT;
            sb.push_back(e);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.req_valid = 1'b0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (sb.size() != 0) begin
            fail_now("drain");
            sb.delete();
        end
        repeat (2) @(posedge CLK);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset         = 1'b1;
        ld_en         = 1'b0;
        ld_addr       = '0;
        ld_data       = '0;
        bus.req_valid = 1'b1;
        bus.req_addr  = '0;
        bus.rsp_ready = 1'b1;

        // Reset state; a load during reset must still land, a request must not.
        repeat (2) @(posedge CLK);
        #1;
        ld(5, 32'h12345678);
        @(negedge CLK);
        check("reset_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        check("reset_req_ready", 64'(bus.req_ready), 64'h1);
        check("reset_rsp_data", 64'(bus.rsp_data), 64'h0);
        check("reset_rsp_fault", 64'(bus.rsp_fault), 64'h0);
        check("reset_fault_cnt", 64'(fault_cnt), 64'h0);
        @(posedge CLK);
        #1;
        bus.req_valid = 1'b0;
        Reset = 1'b0;

        // Load and stream with exact latency.
        ld(0, 32'h910003E1);
        ld(1, 32'h910007E2);
        ld(2, 32'h8B020021);
        ld(3, 32'h8B020022);
        chk_lat = 1'b1;
        fetch(64'h0, 32'h910003E1, 2'b00);
        fetch(64'h4, 32'h910007E2, 2'b00);
        fetch(64'h8, 32'h8B020021, 2'b00);
        fetch(64'hC, 32'h8B020022, 2'b00);
        drain();
        chk_lat = 1'b0;

        // Backpressure: three refused cycles once the first response shows.
        fork
            begin
                fetch(64'h0, 32'h910003E1, 2'b00);
                fetch(64'h4, 32'h910007E2, 2'b00);
                fetch(64'h8, 32'h8B020021, 2'b00);
                fetch(64'hC, 32'h8B020022, 2'b00);
                bus.req_valid = 1'b0;
            end
            begin
                int n;
                n = 0;
                do begin
                    @(posedge CLK);
                    #2;
                    n++;
                end while (!bus.rsp_valid && n < 20);
                if (!bus.rsp_valid) fail_now("bp_first_rsp");
                bus.rsp_ready = 1'b0;
                repeat (3) @(posedge CLK);
                #2;
                bus.rsp_ready = 1'b1;
            end
        join
        drain();

        // Fault decoding and counting.
        fetch(64'h2,   32'h0, 2'b01);
        fetch(64'h100, 32'h0, 2'b10);
        fetch(64'h103, 32'h0, 2'b01);
        fetch(64'h1000_0000_0000_0000, 32'h0, 2'b10);
        drain();
        check("fault_cnt_after_faults", 64'(fault_cnt), 64'h4);

        // Same-cycle load and fetch of word 2: old data first, new on re-fetch.
        ld_en   = 1'b1;
        ld_addr = 6'd2;
        ld_data = 32'hDEADBEEF;
        fetch(64'h8, 32'h8B020021, 2'b00);
        ld_en = 1'b0;
        fetch(64'h8, 32'hDEADBEEF, 2'b00);
        drain();

        // Reset with two requests in flight: both are discarded.
        fetch(64'h0, 32'h910003E1, 2'b00);
        fetch(64'h4, 32'h910007E2, 2'b00);
        Reset         = 1'b1;
        bus.req_valid = 1'b0;
        sb.delete();
        @(posedge CLK);
        #1;
        Reset = 1'b0;
        repeat (6) begin
            @(negedge CLK);
            check("post_reset_quiet", 64'(bus.rsp_valid), 64'h0);
        end
        check("post_reset_fault_cnt", 64'(fault_cnt), 64'h0);

        // Memory contents survive reset; untouched words still hold NOP.
        @(posedge CLK);
        #1;
        fetch(64'h0,  32'h910003E1, 2'b00);
        fetch(64'h4,  32'h910007E2, 2'b00);
        fetch(64'h8,  32'hDEADBEEF, 2'b00);
        fetch(64'hC,  32'h8B020022, 2'b00);
        fetch(64'h14, 32'h12345678, 2'b00);
        fetch(64'h18, 32'hD503201F, 2'b00);
        fetch(64'hFC, 32'hD503201F, 2'b00);
        drain();

        // Counter saturation.
        @(negedge CLK);
        force dut.fault_cnt_q = 16'hFFFE;
        #1;
        release dut.fault_cnt_q;
        @(posedge CLK);
        #1;
        fetch(64'h1, 32'h0, 2'b01);
        fetch(64'h2, 32'h0, 2'b01);
        fetch(64'h3, 32'h0, 2'b01);
        drain();
        check("fault_cnt_saturated", 64'(fault_cnt), 64'hFFFF);
        repeat (5) @(posedge CLK);
        #1;
        check("fault_cnt_holds", 64'(fault_cnt), 64'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
